// File: rtl/axis_block_packer_pkg.sv
// Shared constants and state encoding for the block packer and the cipher core wrapper.
package axis_block_packer_pkg;

  localparam int DATA_W    = 32;
  localparam int ENC_WORDS = 16;
  localparam int DEC_WORDS = 28;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(ENC_WORDS - 1);
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DEC_WORDS - 1);

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } state_t;

endpackage

// File: rtl/axis_block_packer_if.sv
// Stream bundle between the DMA MM2S side, the block packer and the cipher core.
interface axis_block_packer_if
  import axis_block_packer_pkg::*;
();

  logic              encryp_decryp;
  logic [DATA_W-1:0] s_axis_data;
  logic              s_axis_valid;
  logic              s_axis_last;
  logic              s_axis_ready;
  logic [DATA_W-1:0] m_axis_data;
  logic              m_axis_valid;
  logic              m_axis_last;
  logic              m_axis_ready;
  logic              m_msg_end;
  logic [CNT_W-1:0]  m_pad_count;

  // The packer sees the bundle as the slave of the upstream message stream.
  modport slave (
    input  encryp_decryp, s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, m_msg_end, m_pad_count
  );

  modport master (
    output encryp_decryp, s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, m_msg_end, m_pad_count
  );

endinterface

// File: rtl/axis_block_packer.sv
// Re-frames variable-length word messages into fixed 16/28-word blocks,
// zero-padding the final block and reporting how many pad words it holds.
module axis_block_packer
  import axis_block_packer_pkg::*;
(
  input  logic         axis_clk,
  input  logic         axis_reset,
  axis_block_packer_if.slave bus
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  word_cnt, word_cnt_next;
  logic [CNT_W-1:0]  pad_acc, pad_acc_next;
  logic [CNT_W-1:0]  last_idx;
  logic              mode_q, mode_next, mode_eff;
  logic              slot_free;
  logic              s_ready;

  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_end;
  logic [CNT_W-1:0]  load_pad;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_end;
  logic [CNT_W-1:0]  out_pad;

  assign slot_free = !out_valid || bus.m_axis_ready;

  // The word at index 0 opens a block, so it must already see the new mode.
  assign mode_eff  = (word_cnt == '0) ? bus.encryp_decryp : mode_q;
  assign last_idx  = mode_eff ? DEC_LAST : ENC_LAST;

  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    pad_acc_next  = pad_acc;
    mode_next     = mode_q;
    s_ready       = 1'b0;
    load          = 1'b0;
    load_data     = '0;
    load_last     = 1'b0;
    load_end      = 1'b0;
    load_pad      = '0;

    case (state)
      PASS: begin
        s_ready = slot_free;
        if (bus.s_axis_valid && slot_free) begin
          load      = 1'b1;
          load_data = bus.s_axis_data;
          if (word_cnt == last_idx) begin
            load_last     = 1'b1;
            load_end      = bus.s_axis_last;
            word_cnt_next = '0;
          end else begin
            word_cnt_next = word_cnt + CNT_W'(1);
            if (bus.s_axis_last) begin
              state_next   = PAD;
              pad_acc_next = '0;
            end
          end
        end
      end

      PAD: begin
        if (slot_free) begin
          load = 1'b1;
          if (word_cnt == last_idx) begin
            load_last     = 1'b1;
            load_end      = 1'b1;
            load_pad      = pad_acc + CNT_W'(1);
            word_cnt_next = '0;
            pad_acc_next  = '0;
            state_next    = PASS;
          end else begin
            word_cnt_next = word_cnt + CNT_W'(1);
            pad_acc_next  = pad_acc + CNT_W'(1);
          end
        end
      end

      default: state_next = PASS;
    endcase

    if (load && (word_cnt == '0)) begin
      mode_next = bus.encryp_decryp;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state    <= PASS;
      word_cnt <= '0;
      pad_acc  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      pad_acc  <= pad_acc_next;
      mode_q   <= mode_next;
    end
  end

  // Single output register; sideband fields drop to zero once the word is taken.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_end   <= 1'b0;
      out_pad   <= '0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
      out_end   <= load_end;
      out_pad   <= load_pad;
    end else if (bus.m_axis_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_end   <= 1'b0;
      out_pad   <= '0;
    end
  end

  assign bus.s_axis_ready = s_ready;
  assign bus.m_axis_data  = out_data;
  assign bus.m_axis_valid = out_valid;
  assign bus.m_axis_last  = out_last;
  assign bus.m_msg_end    = out_end;
  assign bus.m_pad_count  = out_pad;

endmodule

// File: tb/tb_axis_block_packer.sv
// Scoreboard bench for axis_block_packer: a block-framing model queues expected
// words as messages are driven and the output monitor pops and compares them.
module tb_axis_block_packer;
  import axis_block_packer_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              msg_end;
    logic [CNT_W-1:0]  pad;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_block_packer_if bus();

  axis_block_packer dut (
    .axis_clk   (clk),
    .axis_reset (rst),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int first_acc_cyc;
  int first_out_cyc;
  int last_out_cyc;
  bit send_timeout;
  bit bp_done;

  beat_t             exp_q[$];
  beat_t             mon_e;
  logic [DATA_W-1:0] msg[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every word the core takes is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.m_axis_valid && bus.m_axis_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected: got data=%h last=%b end=%b pad=%0d, required no output",
                 bus.m_axis_data, bus.m_axis_last, bus.m_msg_end, bus.m_pad_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.m_axis_data !== mon_e.data || bus.m_axis_last !== mon_e.last ||
            bus.m_msg_end !== mon_e.msg_end || bus.m_pad_count !== mon_e.pad) begin
          failures++;
          $display("[TB] FAIL sb_word: got data=%h last=%b end=%b pad=%0d, required data=%h last=%b end=%b pad=%0d",
                   bus.m_axis_data, bus.m_axis_last, bus.m_msg_end, bus.m_pad_count,
                   mon_e.data, mon_e.last, mon_e.msg_end, mon_e.pad);
        end
      end
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
  end

  // Block-framing model: block length fixed by the mode at block start.
  task automatic push_model(input logic mode);
    int    n;
    int    pos;
    int    pads;
    beat_t b;
    n   = mode ? DEC_WORDS : ENC_WORDS;
    pos = 0;
    for (int i = 0; i < msg.size(); i++) begin
      b.data    = msg[i];
      b.last    = (pos == n - 1);
      b.msg_end = (pos == n - 1) && (i == msg.size() - 1);
      b.pad     = '0;
      exp_q.push_back(b);
      pos = (pos == n - 1) ? 0 : pos + 1;
    end
    if (pos != 0) begin
      pads = n - pos;
      for (int k = 1; k <= pads; k++) begin
        b.data    = '0;
        b.last    = (k == pads);
        b.msg_end = (k == pads);
        b.pad     = (k == pads) ? CNT_W'(pads) : '0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_msg(input logic mode, input int toggle_at);
    int t;
    send_timeout      = 1'b0;
    bus.encryp_decryp = mode;
    for (int i = 0; i < msg.size(); i++) begin
      if (i == toggle_at) bus.encryp_decryp = ~mode;
      bus.s_axis_valid = 1'b1;
      bus.s_axis_data  = msg[i];
      bus.s_axis_last  = (i == msg.size() - 1);
      t = 0;
      @(negedge clk);
      while (!bus.s_axis_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!bus.s_axis_ready) begin
        send_timeout = 1'b1;
        break;
      end
      if (i == 0) first_acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    bus.s_axis_valid = 1'b0;
    bus.s_axis_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 32'hDEADBEEF;
    bus.m_axis_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got valid/last/end=%b, required 000",
               {bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end});
    end
    checks++;
    if (bus.m_axis_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h, required 0", bus.m_axis_data);
    end
    checks++;
    if (bus.m_pad_count !== '0) begin
      failures++;
      $display("[TB] FAIL reset_pad: got %0d, required 0", bus.m_pad_count);
    end
    bus.s_axis_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_s_ready: got %b, required 1", bus.s_axis_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_block();
    msg.delete();
    for (int i = 1; i <= 16; i++) msg.push_back(DATA_W'(i));
    first_out_cyc = -1;
    push_model(1'b0);
    send_msg(1'b0, -1);
    wait_drain();
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_drain: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
    checks++;
    if (first_out_cyc != first_acc_cyc + 1) begin
      failures++;
      $display("[TB] FAIL full_latency: got first out at %0d, required %0d", first_out_cyc, first_acc_cyc + 1);
    end
    checks++;
    if (last_out_cyc - first_out_cyc != 15) begin
      failures++;
      $display("[TB] FAIL full_rate: got span %0d cycles, required 15", last_out_cyc - first_out_cyc);
    end
  endtask

  task automatic test_pad();
    int busy;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(32'hA0 + DATA_W'(i));
    push_model(1'b0);
    send_msg(1'b0, -1);
    busy = 0;
    repeat (11) begin
      @(negedge clk);
      if (bus.s_axis_ready !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin
      failures++;
      $display("[TB] FAIL pad_s_ready_low: got %0d ready cycles during pad, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (bus.s_axis_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pad_s_ready_back: got %b after pad, required 1", bus.s_axis_ready);
    end
    wait_drain();
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pad_drain: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
  endtask

  task automatic test_multi_block();
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(32'h100 + DATA_W'(i));
    push_model(1'b0);
    send_msg(1'b0, -1);
    wait_drain();
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL multi_drain: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
  endtask

  task automatic test_decrypt();
    msg.delete();
    for (int i = 0; i < 28; i++) msg.push_back(32'h200 + DATA_W'(i));
    push_model(1'b1);
    send_msg(1'b1, 10);
    wait_drain();
    bus.encryp_decryp = 1'b0;
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL dec_drain: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] sv_data;
    logic [2:0]        sv_flags;
    logic [CNT_W-1:0]  sv_pad;
    bit                held;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(32'hA0 + DATA_W'(i));
    push_model(1'b0);
    bp_done = 1'b0;
    fork
      begin
        send_msg(1'b0, -1);
        wait_drain();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          bus.m_axis_ready = ~bus.m_axis_ready;
        end
        bus.m_axis_ready = 1'b1;
      end
      begin
        held = 1'b0;
        while (!bp_done) begin
          @(negedge clk);
          if (held) begin
            checks++;
            if (bus.m_axis_data !== sv_data || bus.m_pad_count !== sv_pad ||
                {bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end} !== sv_flags) begin
              failures++;
              $display("[TB] FAIL bp_stable: got data=%h flags=%b pad=%0d, required data=%h flags=%b pad=%0d",
                       bus.m_axis_data, {bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end}, bus.m_pad_count,
                       sv_data, sv_flags, sv_pad);
            end
          end
          if (bus.m_axis_valid && !bus.m_axis_ready) begin
            checks++;
            if (bus.s_axis_ready !== 1'b0) begin
              failures++;
              $display("[TB] FAIL bp_s_ready: got %b while stalled, required 0", bus.s_axis_ready);
            end
            sv_data  = bus.m_axis_data;
            sv_pad   = bus.m_pad_count;
            sv_flags = {bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end};
            held     = 1'b1;
          end else begin
            held = 1'b0;
          end
        end
      end
    join
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL bp_drain: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_pad();
    beat_t b;
    msg.delete();
    for (int i = 0; i < 3; i++) msg.push_back(32'h31 + DATA_W'(i));
    b.last = 1'b0; b.msg_end = 1'b0; b.pad = '0;
    for (int i = 0; i < 3; i++) begin
      b.data = msg[i];
      exp_q.push_back(b);
    end
    b.data = '0;
    exp_q.push_back(b);
    exp_q.push_back(b);
    send_msg(1'b0, -1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end} !== 3'b000 ||
        bus.m_axis_data !== '0 || bus.m_pad_count !== '0) begin
      failures++;
      $display("[TB] FAIL rst_pad_outputs: got valid/last/end=%b data=%h pad=%0d, required all 0",
               {bus.m_axis_valid, bus.m_axis_last, bus.m_msg_end}, bus.m_axis_data, bus.m_pad_count);
    end
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rst_pad_words: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
    @(posedge clk);
    #1;
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(32'h400 + DATA_W'(i));
    push_model(1'b0);
    send_msg(1'b0, -1);
    wait_drain();
    checks++;
    if (send_timeout || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rst_pad_next_msg: got timeout=%b left=%0d, required 0/0", send_timeout, exp_q.size());
    end
  endtask

  initial begin
    bus.encryp_decryp = 1'b0;
    bus.s_axis_valid  = 1'b0;
    bus.s_axis_data   = '0;
    bus.s_axis_last   = 1'b0;
    bus.m_axis_ready  = 1'b1;
    first_out_cyc     = -1;
    first_acc_cyc     = 0;
    last_out_cyc      = 0;
    rst               = 1'b1;

    test_reset();
    test_full_block();
    test_pad();
    test_multi_block();
    test_decrypt();
    test_backpressure();
    test_reset_mid_pad();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000 ns, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
